// File: rtl/mem_bridge.sv
// mem_bridge: routes pipeline loads/stores to data memory (single cycle),
// to a handshaked peripheral port (with timeout), or flags them as unmapped.
//
// Handshake: a request is sampled only while the bridge is idle. Data-memory
// and unmapped accesses never stall; a peripheral access raises stall in the
// cycle it is presented and keeps it high until the peripheral acks or the
// wait budget expires. The following response cycle drops stall so the
// pipeline can retire the access. Requests seen during that response cycle
// are ignored. rdata_valid / bus_err are one-cycle pulses; rdata is held.
module mem_bridge #(
    parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
    parameter logic [31:0] PER_BASE = 32'h0000_7F00,
    parameter logic [31:0] PER_TOP  = 32'h0000_7F2F,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    input  logic        req_rd,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_err,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        per_req,
    output logic [3:0]  per_we,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    input  logic        per_ack,
    input  logic [31:0] per_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PER_WAIT = 2'd1,
        RESP     = 2'd2
    } state_t;

    // Last wait-cycle index; reaching it without ack ends the access.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        bus_err_q, bus_err_d;

    logic        is_store;
    logic        active;
    logic        hit_dm;
    logic        hit_per;
    logic        stall_c;
    logic [3:0]  dm_we_c;

    // Address decode and access classification (store wins over load).
    always_comb begin
        is_store = (req_byteen != 4'd0);
        active   = req_valid && (is_store || req_rd);
        hit_dm   = (req_addr <= DM_TOP);
        hit_per  = (req_addr >= PER_BASE) && (req_addr <= PER_TOP);
    end

    // Next-state, latches, response registers and combinational strobes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;
        stall_c       = 1'b0;
        dm_we_c       = 4'd0;
        case (state_q)
            IDLE: begin
                if (active) begin
                    if (hit_dm) begin
                        if (is_store) begin
                            dm_we_c = req_byteen;
                        end else begin
                            rdata_d       = dm_rdata;
                            rdata_valid_d = 1'b1;
                        end
                    end else if (hit_per) begin
                        addr_d  = req_addr;
                        be_d    = req_byteen;
                        wdata_d = req_wdata;
                        rd_d    = !is_store;
                        cnt_d   = 8'd0;
                        stall_c = 1'b1;
                        state_d = PER_WAIT;
                    end else begin
                        rdata_d   = 32'd0;
                        bus_err_d = 1'b1;
                    end
                end
            end
            PER_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (per_ack) begin
                    rdata_d       = rd_q ? per_rdata : 32'd0;
                    rdata_valid_d = rd_q;
                    state_d       = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = 32'd0;
                    bus_err_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            addr_q        <= 32'd0;
            be_q          <= 4'd0;
            wdata_q       <= 32'd0;
            rd_q          <= 1'b0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            rd_q          <= rd_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // Output drive; request-dependent strobes are gated while in reset.
    always_comb begin
        stall       = reset_n && stall_c;
        dm_we       = reset_n ? dm_we_c : 4'd0;
        dm_addr     = req_addr;
        dm_wdata    = req_wdata;
        per_req     = (state_q == PER_WAIT);
        per_we      = (state_q == PER_WAIT) ? be_q : 4'd0;
        per_addr    = addr_q;
        per_wdata   = wdata_q;
        rdata       = rdata_q;
        rdata_valid = rdata_valid_q;
        bus_err     = bus_err_q;
        dbg_state   = state_q;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter DM_TOP, 32'h0000_2FFF, highest data-memory byte address; DM range is 0..DM_TOP.
REQ-002 Parameter PER_BASE, 32'h0000_7F00, first peripheral byte address.
REQ-003 Parameter PER_TOP, 32'h0000_7F2F, last peripheral byte address.
REQ-004 Parameter TIMEOUT, 16, maximum wait cycles for per_ack; legal range 2..255.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  memory access presented by the byte-enable stage this cycle.
REQ-008 req_addr  in  32  access byte address.
REQ-009 req_byteen  in  4  store byte lanes; nonzero means store.
REQ-010 req_wdata  in  32  lane-aligned store data.
REQ-011 req_rd  in  1  load request.
REQ-012 stall  out  1  pipeline must hold the current request.
REQ-013 rdata  out  32  load result word.
REQ-014 rdata_valid  out  1  one-cycle pulse qualifying rdata.
REQ-015 bus_err  out  1  one-cycle pulse: unmapped address or peripheral timeout.
REQ-016 dm_we  out  4 / dm_addr  out  32 / dm_wdata  out  32: data-memory port.
REQ-017 dm_rdata  in  32  data-memory read word, combinational from dm_addr.
REQ-018 per_req  out  1 / per_we  out  4 / per_addr  out  32 / per_wdata  out  32: peripheral port.
REQ-019 per_ack  in  1 / per_rdata  in  32: peripheral completion and read data.

Function
REQ-020 Decode: DM if addr <= DM_TOP; PER if PER_BASE <= addr <= PER_TOP; otherwise UNMAPPED.
REQ-021 Active access: req_valid and (req_byteen != 0 or req_rd); byteen != 0 with req_rd treated as store and req_rd ignored.
REQ-022 FSM states: IDLE, PER_WAIT, RESP; reset state IDLE.
REQ-023 IDLE + DM store: dm_we = req_byteen, dm_addr/dm_wdata = request, same cycle; no stall; state stays IDLE.
REQ-024 IDLE + DM load: dm_we = 0, dm_addr = req_addr; rdata <= dm_rdata and rdata_valid = 1 in next cycle; no stall.
REQ-025 dm_we = 0 in every cycle not covered by REQ-023.
REQ-026 IDLE + PER access: latch addr, byteen, wdata, read flag; stall = 1 same cycle; go to PER_WAIT; wait counter cleared.
REQ-027 PER_WAIT: per_req = 1, per_we/per_addr/per_wdata from latched values; stall = 1; counter increments each cycle.
REQ-028 PER_WAIT + per_ack: latch per_rdata if read, else zero; go to RESP; stall = 1 in ack cycle.
REQ-029 PER_WAIT, counter reaches TIMEOUT without ack: go to RESP with error flag set, rdata forced to 0.
REQ-030 RESP (one cycle): per_req = 0, stall = 0; rdata_valid = 1 only for a read without error; bus_err = 1 if error; return to IDLE.
REQ-031 New requests in RESP are not accepted; the held request is accepted in the following IDLE cycle.
REQ-032 IDLE + UNMAPPED access: no DM or peripheral activity; bus_err = 1 and rdata = 0 in next cycle, with rdata_valid = 0; no stall.
REQ-033 per_ack outside PER_WAIT is ignored.
REQ-034 req_valid with byteen = 0 and req_rd = 0 is a no-op.

Reset
REQ-035 reset_n low forces the FSM to IDLE and clears the counter and latches at once, without waiting for a clock edge.
REQ-036 During reset: stall = 0, rdata = 0, rdata_valid = 0, bus_err = 0, dm_we = 0, per_req = 0, per_we = 0.
REQ-037 Reset during PER_WAIT drops per_req immediately; the pending access is discarded with no response.

Verification
REQ-038 DM store, addr 0x0000_0104, byteen 4'b0100, wdata 0x00AB_0000 -> dm_we = 4'b0100 same cycle; stall stays 0.
REQ-039 DM load, addr 0x0000_0104, dm_rdata 0x1234_5678 -> next cycle rdata = 0x1234_5678, rdata_valid = 1.
REQ-040 PER load, addr 0x7F04; per_ack asserted on the 3rd PER_WAIT cycle with per_rdata 0x0000_0010 -> stall held 4 cycles; RESP gives rdata = 0x10, rdata_valid = 1.
REQ-041 PER store, addr 0x7F10, ack never asserted, TIMEOUT = 16 -> per_req high 16 cycles; then bus_err = 1, rdata_valid = 0, FSM back to IDLE.
REQ-042 Load from 0x0000_5000 -> next cycle bus_err = 1, rdata = 0; no dm_we and no per_req activity.
REQ-043 reset_n pulled low mid-PER_WAIT -> per_req and stall drop to 0 without a clock edge; after release, a DM load completes normally.
